// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/exception sequencer for the in-order MIPS pipeline: MD unit occupancy,
// branch-correction flushes, and interrupt deferral around branches and delay slots.
module pipeline_hazard_ctrl #(
  parameter int STAGES     = 5,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int INT_LINES  = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_use,
  input  logic                 md_start,
  input  logic                 md_is_div,
  input  logic                 md_use_id,
  input  logic                 id_is_ctrl,
  input  logic                 eret_id,
  input  logic [STAGES-1:0]    correct,
  input  logic [INT_LINES-1:0] int_req,
  input  logic [INT_LINES-1:0] int_mask,
  input  logic                 exl,
  output logic                 pc_write,
  output logic [STAGES-1:0]    stage_stall,
  output logic [STAGES-1:0]    stage_flush,
  output logic                 md_busy,
  output logic                 exl_set,
  output logic                 exl_clr,
  output logic [INT_LINES-1:0] int_cause,
  output logic                 int_deferred
);

  localparam int MD_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW     = (MD_MAX < 2) ? 1 : $clog2(MD_MAX);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DEFER = 2'd1,
    ST_TAKE  = 2'd2
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_md_cnt;
  logic                  r_ds_flag;
  logic [INT_LINES-1:0]  r_int_cause;

  logic                  w_md_busy;
  logic                  w_stall_req;
  logic                  w_corr_any;
  logic [STAGES-1:0]     w_corr_mask;
  logic [STAGES-1:0]     w_stall;
  logic [STAGES-1:0]     w_flush;
  logic                  w_eret_take;
  logic                  w_pending;
  logic                  w_take_cond;
  logic                  w_exl_set;
  logic                  w_deferred;
  logic                  w_unused_corr;

  // Corrections can only resolve in EX or later; bits 0/1 carry no meaning.
  assign w_unused_corr = ^correct[1:0];

  assign w_md_busy   = (r_md_cnt != '0) || md_start;
  assign w_stall_req = load_use || (w_md_busy && md_use_id);
  assign w_corr_any  = |correct[STAGES-1:2];
  assign w_pending   = (|(int_req & int_mask)) && !exl;

  // A correction at stage k squashes everything younger than its delay slot at k-1.
  always_comb begin
    w_corr_mask = '0;
    for (int j = 0; j < STAGES - 2; j++) begin
      for (int k = j + 2; k < STAGES; k++) begin
        if (correct[k]) w_corr_mask[j] = 1'b1;
      end
    end
  end

  assign w_eret_take = eret_id && !w_stall_req && !w_corr_any;
  assign w_take_cond = w_pending && !w_corr_any && !w_stall_req && !id_is_ctrl &&
                       !r_ds_flag && !w_eret_take;
  assign w_exl_set   = (r_state == ST_TAKE) && w_pending && !w_corr_any &&
                       !w_stall_req && !w_eret_take;
  assign w_deferred  = w_pending && !w_take_cond && !w_exl_set;

  always_comb begin
    w_stall      = '0;
    w_stall[1:0] = {2{w_stall_req}};
    w_stall      = w_stall & ~w_corr_mask;
    w_flush      = w_corr_mask;
    w_flush[2]   = w_flush[2] | w_stall_req;
    w_flush[0]   = w_flush[0] | w_exl_set | w_eret_take;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_md_cnt    <= '0;
      r_ds_flag   <= 1'b0;
      r_int_cause <= '0;
    end else begin
      // EX never stalls here, so every md_start is an accepted issue.
      if (md_start) begin
        r_md_cnt <= md_is_div ? DIV_LOAD : MUL_LOAD;
      end else if (r_md_cnt != '0) begin
        r_md_cnt <= r_md_cnt - 1'b1;
      end

      if (!w_stall[1]) r_ds_flag <= id_is_ctrl;

      if (w_exl_set) r_int_cause <= int_req & int_mask;

      if (w_exl_set) begin
        r_state <= ST_RUN;
      end else if (w_take_cond) begin
        r_state <= ST_TAKE;
      end else if (w_pending) begin
        r_state <= ST_DEFER;
      end else begin
        r_state <= ST_RUN;
      end
    end
  end

  always_comb begin
    pc_write     = 1'b0;
    stage_stall  = '0;
    stage_flush  = '0;
    md_busy      = 1'b0;
    exl_set      = 1'b0;
    exl_clr      = 1'b0;
    int_cause    = '0;
    int_deferred = 1'b0;
    if (!reset) begin
      pc_write     = w_corr_any || !w_stall_req;
      stage_stall  = w_stall;
      stage_flush  = w_flush;
      md_busy      = w_md_busy;
      exl_set      = w_exl_set;
      exl_clr      = w_eret_take;
      int_cause    = r_int_cause;
      int_deferred = w_deferred;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: reset, MD occupancy, corrections,
// interrupt deferral, masking, eret ordering.
module tb_pipeline_hazard_ctrl;

  localparam int STAGES    = 5;
  localparam int INT_LINES = 6;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 load_use, md_start, md_is_div, md_use_id;
  logic                 id_is_ctrl, eret_id, exl;
  logic [STAGES-1:0]    correct;
  logic [INT_LINES-1:0] int_req, int_mask;
  logic                 pc_write, md_busy, exl_set, exl_clr, int_deferred;
  logic [STAGES-1:0]    stage_stall, stage_flush;
  logic [INT_LINES-1:0] int_cause;

  // {pc_write, stage_stall, stage_flush, md_busy, exl_set, exl_clr, int_deferred}
  logic [14:0] obs;
  logic [14:0] exp_v;
  int          n_tests = 0;
  int          n_fail  = 0;

  assign obs = {pc_write, stage_stall, stage_flush, md_busy, exl_set, exl_clr, int_deferred};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .STAGES(STAGES), .MUL_CYCLES(5), .DIV_CYCLES(10), .INT_LINES(INT_LINES)
  ) dut (
    .clk(clk), .reset(reset), .load_use(load_use), .md_start(md_start),
    .md_is_div(md_is_div), .md_use_id(md_use_id), .id_is_ctrl(id_is_ctrl),
    .eret_id(eret_id), .correct(correct), .int_req(int_req), .int_mask(int_mask),
    .exl(exl), .pc_write(pc_write), .stage_stall(stage_stall),
    .stage_flush(stage_flush), .md_busy(md_busy), .exl_set(exl_set),
    .exl_clr(exl_clr), .int_cause(int_cause), .int_deferred(int_deferred)
  );

  task automatic drive_idle();
    reset = 1'b0; load_use = 1'b0; md_start = 1'b0; md_is_div = 1'b0;
    md_use_id = 1'b0; id_is_ctrl = 1'b0; eret_id = 1'b0; exl = 1'b0;
    correct = '0; int_req = '0; int_mask = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1; md_start = 1'b1; md_is_div = 1'b1; md_use_id = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (obs !== 15'd0 || int_cause !== 6'd0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got=%b/%b exp=%b/000000", i, obs, int_cause, 15'd0);
      end
      n_tests++;
      next_cycle();
    end
    drive_idle();
    @(negedge clk);
    exp_v = {1'b1, 5'b00000, 5'b00000, 4'b0000};
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL reset_release got=%b exp=%b", obs, exp_v);
    end
    n_tests++;
    next_cycle();
  endtask

  task automatic test_divide();
    drive_idle();
    md_start = 1'b1; md_is_div = 1'b1;
    @(negedge clk);
    exp_v = {1'b1, 5'b00000, 5'b00000, 4'b1000};
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL div_issue got=%b exp=%b", obs, exp_v);
    end
    n_tests++;
    next_cycle();
    md_start = 1'b0; md_is_div = 1'b0; md_use_id = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i < 10) exp_v = {1'b0, 5'b00011, 5'b00100, 4'b1000};
      else        exp_v = {1'b1, 5'b00000, 5'b00000, 4'b0000};
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL div_busy cyc=%0d got=%b exp=%b", i, obs, exp_v);
      end
      n_tests++;
      next_cycle();
    end
    drive_idle();
  endtask

  task automatic test_mult();
    drive_idle();
    md_start = 1'b1; md_use_id = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i < 5) exp_v = {1'b0, 5'b00011, 5'b00100, 4'b1000};
      else       exp_v = {1'b1, 5'b00000, 5'b00000, 4'b0000};
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL mult_busy cyc=%0d got=%b exp=%b", i, obs, exp_v);
      end
      n_tests++;
      next_cycle();
      md_start = 1'b0;
    end
    drive_idle();
  endtask

  task automatic test_correct();
    drive_idle();
    load_use = 1'b1;
    @(negedge clk);
    exp_v = {1'b0, 5'b00011, 5'b00100, 4'b0000};
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL load_use got=%b exp=%b", obs, exp_v);
    end
    n_tests++;
    next_cycle();
    correct = 5'b01000;
    @(negedge clk);
    if (stage_flush[1:0] !== 2'b11 || stage_stall !== 5'b00000 || pc_write !== 1'b1) begin
      n_fail++;
      $display("FAIL corr_mem flush10=%b stall=%b pc=%b exp 11/00000/1",
               stage_flush[1:0], stage_stall, pc_write);
    end
    n_tests++;
    next_cycle();
    correct = 5'b00100;
    @(negedge clk);
    exp_v = {1'b1, 5'b00010, 5'b00101, 4'b0000};
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL corr_ex_stall got=%b exp=%b", obs, exp_v);
    end
    n_tests++;
    next_cycle();
    load_use = 1'b0; correct = 5'b10000;
    @(negedge clk);
    exp_v = {1'b1, 5'b00000, 5'b00111, 4'b0000};
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL corr_top got=%b exp=%b", obs, exp_v);
    end
    n_tests++;
    next_cycle();
    drive_idle();
  endtask

  task automatic test_int_branch();
    drive_idle();
    int_req = 6'b000100; int_mask = 6'b111111;
    for (int i = 0; i < 4; i++) begin
      id_is_ctrl = (i == 0);
      @(negedge clk);
      case (i)
        0, 1:    exp_v = {1'b1, 5'b00000, 5'b00000, 4'b0001};
        2:       exp_v = {1'b1, 5'b00000, 5'b00000, 4'b0000};
        default: exp_v = {1'b1, 5'b00000, 5'b00001, 4'b0100};
      endcase
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL int_branch cyc=%0d got=%b exp=%b", i, obs, exp_v);
      end
      n_tests++;
      next_cycle();
    end
    exl = 1'b1; int_req = 6'b000000;
    @(negedge clk);
    if (int_cause !== 6'b000100 || exl_set !== 1'b0) begin
      n_fail++;
      $display("FAIL int_cause_capture got=%b/%b exp=000100/0", int_cause, exl_set);
    end
    n_tests++;
    next_cycle();
    drive_idle();
  endtask

  task automatic test_masked();
    drive_idle();
    int_req = 6'b000001;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin int_mask = 6'b111111; exl = 1'b1; end
      @(negedge clk);
      exp_v = {1'b1, 5'b00000, 5'b00000, 4'b0000};
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL masked cyc=%0d got=%b exp=%b", i, obs, exp_v);
      end
      n_tests++;
      next_cycle();
    end
    drive_idle();
    int_req = 6'b000010; int_mask = 6'b111111; id_is_ctrl = 1'b1;
    @(negedge clk);
    exp_v = {1'b1, 5'b00000, 5'b00000, 4'b0001};
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL drop_defer got=%b exp=%b", obs, exp_v);
    end
    n_tests++;
    next_cycle();
    int_req = 6'b000000; id_is_ctrl = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_v = {1'b1, 5'b00000, 5'b00000, 4'b0000};
      if (obs !== exp_v || int_cause !== 6'b000100) begin
        n_fail++;
        $display("FAIL drop_quiet cyc=%0d got=%b/%b exp=%b/000100", i, obs, int_cause, exp_v);
      end
      n_tests++;
      next_cycle();
    end
    drive_idle();
  endtask

  task automatic test_eret();
    drive_idle();
    int_req = 6'b001000; int_mask = 6'b111111; eret_id = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      case (i)
        0:       exp_v = {1'b1, 5'b00000, 5'b00001, 4'b0011};
        1:       exp_v = {1'b1, 5'b00000, 5'b00000, 4'b0000};
        default: exp_v = {1'b1, 5'b00000, 5'b00001, 4'b0100};
      endcase
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL eret_vs_int cyc=%0d got=%b exp=%b", i, obs, exp_v);
      end
      n_tests++;
      next_cycle();
      eret_id = 1'b0;
    end
    exl = 1'b1; int_req = 6'b000000;
    @(negedge clk);
    if (int_cause !== 6'b001000) begin
      n_fail++;
      $display("FAIL eret_cause got=%b exp=001000", int_cause);
    end
    n_tests++;
    next_cycle();
    drive_idle();
  endtask

  task automatic test_stall_blocks();
    drive_idle();
    eret_id = 1'b1; load_use = 1'b1;
    @(negedge clk);
    exp_v = {1'b0, 5'b00011, 5'b00100, 4'b0000};
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL eret_stalled got=%b exp=%b", obs, exp_v);
    end
    n_tests++;
    next_cycle();
    eret_id = 1'b0; int_req = 6'b010000; int_mask = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      case (i)
        0:       exp_v = {1'b0, 5'b00011, 5'b00100, 4'b0001};
        1:       exp_v = {1'b1, 5'b00000, 5'b00000, 4'b0000};
        default: exp_v = {1'b1, 5'b00000, 5'b00001, 4'b0100};
      endcase
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL int_stalled cyc=%0d got=%b exp=%b", i, obs, exp_v);
      end
      n_tests++;
      next_cycle();
      load_use = 1'b0;
    end
    drive_idle();
  endtask

  task automatic test_reset_mid_md();
    drive_idle();
    md_start = 1'b1; md_is_div = 1'b1;
    next_cycle();
    drive_idle();
    next_cycle();
    reset = 1'b1;
    next_cycle();
    drive_idle();
    md_use_id = 1'b1;
    @(negedge clk);
    exp_v = {1'b1, 5'b00000, 5'b00000, 4'b0000};
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL reset_mid_md got=%b exp=%b", obs, exp_v);
    end
    n_tests++;
    next_cycle();
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_divide();
    test_mult();
    test_correct();
    test_int_branch();
    test_masked();
    test_eret();
    test_stall_blocks();
    test_reset_mid_md();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Sequential stall/flush/exception sequencer for the in-order MIPS pipeline. It sits beside the instruction decoder and is parametrised in stage count and interrupt line count. Unlike the purely combinational control path, it tracks multi-cycle multiply/divide occupancy and resolves branch corrections at any stage. It also defers interrupts around branches and delay slots instead of dropping them, then asserts EXL/flush at a safe boundary.

Parameters:
STAGES, 5, pipeline stage count; bit 0=IF, 1=ID, 2=EX, 3=MEM, ...; legal range 3..8
MUL_CYCLES, 5, busy cycles of the MD unit for mult/multu; must be >=1
DIV_CYCLES, 10, busy cycles of the MD unit for div/divu; must be >=1
INT_LINES, 6, hardware interrupt request lines

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
load_use  in  1  data hazard detected on the ID instruction
md_start  in  1  EX issues mult/div (single-cycle pulse per instruction)
md_is_div  in  1  qualifies md_start: 1=div/divu, 0=mult/multu
md_use_id  in  1  ID instruction touches HI/LO (mfhi/mflo/mthi/mtlo/mult/div)
id_is_ctrl  in  1  ID holds a branch/jump/jr/jalr
eret_id  in  1  ID holds eret
correct  in  STAGES  bit k = mispredict resolved in stage k; at most one bit set
int_req  in  INT_LINES  raw interrupt lines
int_mask  in  INT_LINES  CP0 IM bits
exl  in  1  current CP0 EXL
pc_write  out  1  PC register write enable
stage_stall  out  STAGES  hold pipeline register of stage k
stage_flush  out  STAGES  bubble into pipeline register of stage k
md_busy  out  1  MD unit occupied
exl_set  out  1  one-cycle pulse: take interrupt (CP0 sets EXL, saves EPC)
exl_clr  out  1  one-cycle pulse: eret commit
int_cause  out  INT_LINES  registered pending lines captured at exl_set
int_deferred  out  1  interrupt pending but held back

Behaviour:
- Reset (sync): state RUN, md counter 0, delay-slot flag 0, int_cause 0. Every output is 0 while reset is high and in the cycle after reset falls, except pc_write, which is 1 after reset falls.
- MD counter: md_start in a non-stalled cycle loads MUL_CYCLES-1 or DIV_CYCLES-1. The counter decrements each cycle to 0. md_busy = (counter != 0) or (md_start this cycle).
- md_hazard = md_busy && md_use_id. stall_req = load_use || md_hazard.
- stall_req: stage_stall[0] and [1] = 1, stage_flush[2] = 1, pc_write = 0.
- correct[k] (k>=2): stage_flush[j] = 1 for j = 0..k-2, so the delay slot at k-1 survives. pc_write = 1. stage_stall is cleared on flushed stages. If k = 2 and stall_req is also high: ID stays stalled, IF is flushed, and the PC loads the corrected target.
- Delay-slot flag: registered id_is_ctrl, updated only when ID is not stalled. A high flag means the current ID instruction is a delay slot.
- pending = |(int_req & int_mask) && !exl.
- FSM RUN:
  - pending, no correct, no stall_req, !id_is_ctrl, !flag: go to TAKE.
  - Otherwise pending: go to DEFER, int_deferred = 1.
- FSM DEFER: same take condition is re-evaluated each cycle. If pending drops, return to RUN silently.
- FSM TAKE (1 cycle):
  - exl_set = 1, stage_flush[0] = 1, int_cause <= int_req & int_mask.
  - Return to RUN.
- eret_id, not stalled, no correct: exl_clr = 1 for one cycle and stage_flush[0] = 1. An eret in the same cycle as a take condition wins; the interrupt is deferred.
- Priority: reset > correct > stall_req > eret > interrupt.
- Stalled cycles never issue exl_set or exl_clr.
- int_cause holds its value until the next exl_set.
- Counter behaviour at reset mid-MD-operation: the counter clears immediately.

Test Plan:
- Reset: hold reset 3 cycles with md_start=1 -> all outputs 0, md_busy 0; the cycle after release gives pc_write=1.
- Divide: md_start=1, md_is_div=1, then md_use_id=1 held -> md_busy for 10 cycles; stage_stall=5'b00011, stage_flush=5'b00100, pc_write=0 during cycles 1..9; release on the 10th.
- Correction at MEM: correct=5'b01000 with load_use=1 -> stage_flush[1:0]=2'b11, stage_stall=0, pc_write=1. Correction at EX (5'b00100) with load_use -> flush=5'b00101, stall=5'b00010.
- Interrupt on branch: int_req=6'b000100, int_mask=6'b111111, id_is_ctrl=1 for 1 cycle -> int_deferred for 2 cycles (branch + delay slot), then exl_set pulse, stage_flush[0]=1, int_cause=6'b000100.
- Masked/EXL: int_req=6'b000001 with int_mask=0, or with exl=1 -> no exl_set ever; pending drop while in DEFER -> return to RUN with no pulse.
- eret vs interrupt: eret_id=1 with pending interrupt -> exl_clr pulse first; exl_set follows no earlier than the next cycle.
